buffet_credit_producer: RTL and testbench

Producer-side endpoint of the buffet credit protocol. It requests free-space credits from a buffet, accepts a valid/ready data stream from upstream, and issues buffet fills only while it holds credit. It therefore never overruns the buffet. It sits between any data source (DRAM fetch unit, upstream pipeline) and the buffet's push and credit ports.

---
 rtl/buffet_credit_producer_if.sv | 26 ++
 rtl/buffet_credit_producer.sv | 88 ++++++++
 tb/tb_buffet_credit_producer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/buffet_credit_producer_if.sv
// Handshake bundle between a buffet credit producer, its upstream source and the buffet.
// master = producer block side, slave = upstream source / buffet side.
interface buffet_credit_producer_if #(
  parameter int IDX_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_data_valid;
  logic                  push_data_ready;
  logic [IDX_WIDTH-1:0]  credit_in;
  logic                  credit_valid;
  logic                  credit_ready;

  modport master (
    input  in_data, in_valid, push_data_ready, credit_in, credit_valid,
    output in_ready, push_data, push_data_valid, credit_ready
  );

  modport slave (
    output in_data, in_valid, push_data_ready, credit_in, credit_valid,
    input  in_ready, push_data, push_data_valid, credit_ready
  );
endinterface

// File: rtl/buffet_credit_producer.sv
// Producer endpoint of the buffet credit protocol: fetches absolute free-space snapshots
// and forwards upstream words as buffet fills only while local credit remains.
module buffet_credit_producer #(
  parameter int IDX_WIDTH     = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     nreset_i,
  buffet_credit_producer_if.master bus,
  input  logic                     refresh_i,
  output logic [IDX_WIDTH-1:0]     credit_count,
  output logic                     busy
);

  typedef enum logic [1:0] {REQ = 2'd0, SEND = 2'd1, SETTLE = 2'd2} state_t;

  state_t                state;
  logic [3:0]            settle_cnt;
  logic                  refresh_pending;
  logic [DATA_WIDTH-1:0] push_data_q;
  logic                  push_valid_q;

  logic fire, out_free, accept, send_done;

  assign fire      = push_valid_q && bus.push_data_ready;
  assign out_free  = !push_valid_q || bus.push_data_ready;
  assign send_done = ((credit_count == '0) || refresh_pending) && out_free;

  assign bus.credit_ready    = (state == REQ);
  assign bus.in_ready        = (state == SEND) && (credit_count != '0) && !refresh_pending && out_free;
  assign accept              = bus.in_valid && bus.in_ready;
  assign bus.push_data       = push_data_q;
  assign bus.push_data_valid = push_valid_q;
  assign busy                = (state != REQ) || push_valid_q;

  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      state           <= REQ;
      credit_count    <= '0;
      settle_cnt      <= '0;
      refresh_pending <= 1'b0;
      push_data_q     <= '0;
      push_valid_q    <= 1'b0;
    end else begin
      // A refresh while requesting is moot: the snapshot being taken is already fresh.
      if (refresh_i && state != REQ) refresh_pending <= 1'b1;
      case (state)
        REQ: begin
          if (bus.credit_valid) begin
            credit_count <= bus.credit_in;
            if (bus.credit_in != '0) begin
              state <= SEND;
            end else begin
              state      <= SETTLE;
              settle_cnt <= 4'(SETTLE_CYCLES - 1);
            end
          end
        end
        SEND: begin
          if (accept) begin
            push_data_q  <= bus.in_data;
            push_valid_q <= 1'b1;
            credit_count <= credit_count - IDX_WIDTH'(1);
          end else if (fire) begin
            push_valid_q <= 1'b0;
          end
          // Leave only once no fill is in flight, so the next snapshot is exact.
          if (send_done) begin
            state      <= SETTLE;
            settle_cnt <= 4'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state           <= REQ;
            credit_count    <= '0;
            refresh_pending <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_buffet_credit_producer.sv
// Directed and randomized bench for buffet_credit_producer with a transaction-level model.
module tb_buffet_credit_producer;
  localparam int IW = 6;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic nreset_i;
  logic refresh_i;
  logic [IW-1:0] credit_count;
  logic busy;

  always #5 clk = ~clk;

  buffet_credit_producer_if #(.IDX_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  buffet_credit_producer #(.IDX_WIDTH(IW), .DATA_WIDTH(DW), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .nreset_i(nreset_i), .bus(bus),
    .refresh_i(refresh_i), .credit_count(credit_count), .busy(busy)
  );

  int passed = 0, failed = 0, total = 0;
  int cyc, held, rise;
  bit src_en, chk_busy;
  logic [DW-1:0] src_q[$], acc_q[$], push_q[$];
  logic [IW-1:0] cred_q[$];
  int acc_cyc[$], fire_cyc[$], grant_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin passed++; end
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.in_valid     = src_en && (src_q.size() != 0);
    bus.in_data      = (src_q.size() != 0) ? src_q[0] : '0;
    bus.credit_valid = (cred_q.size() != 0);
    bus.credit_in    = (cred_q.size() != 0) ? cred_q[0] : '0;
  endtask

  // One clock: observe handshakes mid-cycle, update the model, advance past the edge.
  task automatic tick();
    drive();
    @(negedge clk);
    if (bus.credit_valid && bus.credit_ready) begin
      chk("grant_no_pending_push", bus.push_data_valid, 1'b0);
      grant_cyc.push_back(cyc);
      held = bus.credit_in;
      void'(cred_q.pop_front());
    end
    if (bus.in_valid && bus.in_ready) begin
      chk("accept_has_credit", held != 0, 1'b1);
      chk("accept_credit_count", credit_count, held);
      acc_q.push_back(bus.in_data);
      acc_cyc.push_back(cyc);
      void'(src_q.pop_front());
      if (held > 0) held--;
    end
    if (bus.push_data_valid && bus.push_data_ready) begin
      push_q.push_back(bus.push_data);
      fire_cyc.push_back(cyc);
    end
    if (chk_busy) chk("busy_rule", busy, !bus.credit_ready || bus.push_data_valid);
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic reset_dut();
    nreset_i = 1'b0;
    src_q.delete(); acc_q.delete(); push_q.delete(); cred_q.delete();
    acc_cyc.delete(); fire_cyc.delete(); grant_cyc.delete();
    held = 0; src_en = 1'b1; refresh_i = 1'b0; bus.push_data_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    nreset_i = 1'b1;
    cyc = 0;
  endtask

  initial begin
    chk_busy = 1'b0;
    // --- reset values, then first snapshot of 16
    reset_dut();
    nreset_i = 1'b0;
    #1;
    chk("rst_credit_ready", bus.credit_ready, 1'b1);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_push_valid", bus.push_data_valid, 1'b0);
    chk("rst_push_data", bus.push_data, 16'h0);
    chk("rst_credit_count", credit_count, 6'd0);
    chk("rst_busy", busy, 1'b0);
    cred_q.push_back(6'd16);
    drive();
    @(posedge clk); #1;
    nreset_i = 1'b1;
    #1;
    chk("t1_credit_ready_first", bus.credit_ready, 1'b1);
    chk("t1_busy_before", busy, 1'b0);
    tick();
    chk("t1_credit_count", credit_count, 6'd16);
    chk("t1_busy_after", busy, 1'b1);

    // --- credit 8, 10 words offered
    reset_dut();
    cred_q.push_back(6'd8);
    for (int k = 1; k <= 10; k++) src_q.push_back(DW'(k));
    rise = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (grant_cyc.size() != 0 && bus.credit_ready) begin rise = cyc; break; end
    end
    chk("t2_push_count", push_q.size(), 8);
    chk("t2_accept_count", acc_q.size(), 8);
    foreach (push_q[k]) chk("t2_push_word", push_q[k], 32'(k + 1));
    chk("t2_left_upstream", src_q.size(), 2);
    if (src_q.size() != 0) chk("t2_next_upstream", src_q[0], 16'd9);
    if (fire_cyc.size() == 8) begin
      chk("t2_back_to_back", fire_cyc[7] - fire_cyc[0], 7);
      chk("t2_settle_delay", rise - fire_cyc[7], 5);
    end
    if (grant_cyc.size() != 0 && acc_cyc.size() != 0)
      chk("t2_first_accept_lat", acc_cyc[0] - grant_cyc[0], 1);

    // --- credit 3 with buffet stalled after the first push
    reset_dut();
    bus.push_data_ready = 1'b0;
    cred_q.push_back(6'd3);
    src_q.push_back(16'h00A1); src_q.push_back(16'h00A2); src_q.push_back(16'h00A3);
    for (int i = 0; i < 20 && !bus.push_data_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_data", bus.push_data, 16'h00A1);
      chk("t3_stall_in_ready", bus.in_ready, 1'b0);
      tick();
    end
    chk("t3_stall_accepts", acc_q.size(), 1);
    bus.push_data_ready = 1'b1;
    for (int i = 0; i < 30 && push_q.size() < 3; i++) tick();
    chk("t3_push_count", push_q.size(), 3);
    foreach (push_q[k]) chk("t3_push_word", push_q[k], 32'(16'h00A1 + k));

    // --- zero snapshots poll until space appears
    reset_dut();
    cred_q.push_back(6'd0); cred_q.push_back(6'd0); cred_q.push_back(6'd5);
    for (int k = 0; k < 5; k++) src_q.push_back(DW'(16'h0B00 + k));
    for (int i = 0; i < 80 && push_q.size() < 5; i++) tick();
    chk("t4_grants", grant_cyc.size(), 3);
    if (grant_cyc.size() == 3) begin
      chk("t4_gap0", grant_cyc[1] - grant_cyc[0], 5);
      chk("t4_gap1", grant_cyc[2] - grant_cyc[1], 5);
      if (acc_cyc.size() != 0) chk("t4_no_early_push", acc_cyc[0] - grant_cyc[2], 1);
    end
    chk("t4_push_count", push_q.size(), 5);
    foreach (push_q[k]) chk("t4_push_word", push_q[k], 32'(16'h0B00 + k));

    // --- refresh after 3 accepts
    reset_dut();
    cred_q.push_back(6'd16); cred_q.push_back(6'd13);
    for (int k = 0; k < 20; k++) src_q.push_back(DW'(16'h0C00 + k));
    for (int i = 0; i < 10 && grant_cyc.size() == 0; i++) tick();
    chk("t5_first_snapshot", credit_count, 6'd16);
    tick(); tick();
    refresh_i = 1'b1;
    tick();
    refresh_i = 1'b0;
    rise = -1;
    for (int i = 0; i < 40 && grant_cyc.size() < 2; i++) begin
      tick();
      if (rise < 0 && bus.credit_ready) begin rise = cyc; src_en = 1'b0; end
    end
    chk("t5_accepts", acc_q.size(), 3);
    chk("t5_pushes", push_q.size(), 3);
    chk("t5_new_snapshot", credit_count, 6'd13);
    if (fire_cyc.size() == 3) chk("t5_settle_after_fire", rise - fire_cyc[2], 5);
    if (grant_cyc.size() == 2) chk("t5_regrant", grant_cyc[1], rise);

    // --- reset mid-operation
    reset_dut();
    cred_q.push_back(6'd8);
    for (int k = 0; k < 10; k++) src_q.push_back(DW'(16'h0D00 + k));
    for (int i = 0; i < 20 && acc_q.size() < 4; i++) tick();
    src_en = 1'b0;
    bus.push_data_ready = 1'b0;
    drive();
    #1;
    chk("t6_pre_valid", bus.push_data_valid, 1'b1);
    chk("t6_pre_count", credit_count, 6'd4);
    nreset_i = 1'b0;
    #1;
    chk("t6_valid_dropped", bus.push_data_valid, 1'b0);
    chk("t6_count_cleared", credit_count, 6'd0);
    chk("t6_credit_ready", bus.credit_ready, 1'b1);
    chk("t6_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    nreset_i = 1'b1;
    cyc = 0; held = 0;
    cred_q.push_back(6'd5);
    drive();
    #1;
    chk("t6_rerequest", bus.credit_ready, 1'b1);
    tick();
    chk("t6_new_count", credit_count, 6'd5);

    // --- randomized traffic against the transaction model
    reset_dut();
    chk_busy = 1'b1;
    for (int k = 0; k < 40; k++) cred_q.push_back(IW'($urandom_range(0, 6)));
    for (int k = 0; k < 300; k++) src_q.push_back(DW'($urandom));
    for (int i = 0; i < 400; i++) begin
      src_en = ($urandom_range(0, 3) != 0);
      bus.push_data_ready = ($urandom_range(0, 3) != 0);
      refresh_i = ($urandom_range(0, 29) == 0);
      tick();
    end
    src_en = 1'b0; refresh_i = 1'b0; bus.push_data_ready = 1'b1;
    repeat (20) tick();
    chk("rnd_push_vs_accept", push_q.size(), acc_q.size());
    foreach (acc_q[k])
      if (k < push_q.size()) chk("rnd_order", push_q[k], acc_q[k]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
